// File: rtl/lsu_ctrl_pkg.sv
// Shared CPU package: load/store type codes, LSU state encoding and default data width.
// Used by lsu_ctrl, lsu_extend, the data memory and the decoder.
package lsu_ctrl_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;
    localparam logic [1:0] ST_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    // Any load code outside the five defined ones behaves as a full-word load.
    function automatic logic [2:0] norm_load_type(input logic [2:0] lt);
        case (lt)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: return lt;
            default:                             return LD_LW;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extension of a raw little-endian memory word by load type.
module lsu_extend
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = raw;
        case (load_type)
            LD_LB:   data = {{(XLEN-8){raw[7]}}, raw[7:0]};
            LD_LBU:  data = {{(XLEN-8){1'b0}}, raw[7:0]};
            LD_LH:   data = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LD_LHU:  data = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, single-cycle memory access, one-cycle response.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into byte accesses; otherwise they fault.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int XLEN   = LSU_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [2:0]        req_load_type_i,
    input  logic [1:0]        req_store_type_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wr_data_o,
    output logic [2:0]        mem_load_type_o,
    output logic [1:0]        mem_store_type_o,
    input  logic [XLEN-1:0]   mem_rd_data_i,
    output lsu_state_e        dbg_state_o
);

    // Handshake: a request transfers on the rising edge where req_valid_i && req_ready_o;
    // the response is a single-cycle resp_valid_o pulse with no back-pressure.
    lsu_state_e        state;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   asm_q;
    logic [XLEN-1:0]   asm_next;
    logic [XLEN-1:0]   ext_raw;
    logic [XLEN-1:0]   ext_data;
    logic [2:0]        ltype_q;
    logic [1:0]        cnt_q;
    logic [1:0]        last_q;
    logic [1:0]        nxt_cnt;
    logic [2:0]        req_lt;
    logic              req_bad_st;
    logic              req_mis;
    logic [1:0]        req_last;
    logic              finish;

    assign req_ready_o = rst_n && (state == IDLE);
    assign dbg_state_o = state;
    assign nxt_cnt     = cnt_q + 2'd1;
    assign finish      = (state == ACCESS) || (cnt_q == last_q);

    always_comb begin
        req_lt     = norm_load_type(req_load_type_i);
        req_bad_st = req_we_i && (req_store_type_i == ST_BAD);
        req_mis    = 1'b0;
        req_last   = 2'd0;
        if (req_we_i) begin
            if (req_store_type_i == ST_SH) begin
                req_mis  = req_addr_i[0];
                req_last = 2'd1;
            end else if (req_store_type_i == ST_SW) begin
                req_mis  = |req_addr_i[1:0];
                req_last = 2'd3;
            end
        end else begin
            if (req_lt == LD_LH || req_lt == LD_LHU) begin
                req_mis  = req_addr_i[0];
                req_last = 2'd1;
            end else if (req_lt == LD_LW) begin
                req_mis  = |req_addr_i[1:0];
                req_last = 2'd3;
            end
        end
    end

    // Split reads land in byte lane cnt_q; the final byte is merged combinationally before extension.
    always_comb begin
        asm_next = asm_q;
        asm_next[8*cnt_q +: 8] = mem_rd_data_i[7:0];
        ext_raw = (state == SPLIT) ? asm_next : mem_rd_data_i;
    end

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .raw       (ext_raw),
        .load_type (ltype_q),
        .data      (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            we_q             <= 1'b0;
            err_q            <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            asm_q            <= '0;
            ltype_q          <= '0;
            cnt_q            <= '0;
            last_q           <= '0;
            resp_valid_o     <= 1'b0;
            resp_rdata_o     <= '0;
            resp_err_o       <= 1'b0;
            mem_rd_en_o      <= 1'b0;
            mem_wr_en_o      <= 1'b0;
            mem_addr_o       <= '0;
            mem_wr_data_o    <= '0;
            mem_load_type_o  <= '0;
            mem_store_type_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        ltype_q <= req_lt;
                        cnt_q   <= 2'd0;
                        last_q  <= req_last;
                        asm_q   <= '0;
                        err_q   <= 1'b0;
                        state   <= ACCESS;
                        if (req_bad_st) begin
                            err_q <= 1'b1;
                        end else if (req_mis) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                            state            <= SPLIT;
                            mem_rd_en_o      <= !req_we_i;
                            mem_wr_en_o      <= req_we_i;
                            mem_addr_o       <= req_addr_i;
                            mem_wr_data_o    <= req_we_i ? XLEN'(req_wdata_i[7:0]) : '0;
                            mem_load_type_o  <= req_we_i ? LD_LB : LD_LBU;
                            mem_store_type_o <= ST_SB;
`else
                            err_q <= 1'b1;
`endif
                        end else begin
                            mem_rd_en_o      <= !req_we_i;
                            mem_wr_en_o      <= req_we_i;
                            mem_addr_o       <= req_addr_i;
                            mem_wr_data_o    <= req_we_i ? req_wdata_i : '0;
                            mem_load_type_o  <= req_we_i ? LD_LB : req_lt;
                            mem_store_type_o <= req_we_i ? req_store_type_i : ST_SB;
                        end
                    end
                end
                ACCESS, SPLIT: begin
                    if (finish) begin
                        mem_rd_en_o      <= 1'b0;
                        mem_wr_en_o      <= 1'b0;
                        mem_addr_o       <= '0;
                        mem_wr_data_o    <= '0;
                        mem_load_type_o  <= '0;
                        mem_store_type_o <= '0;
                        resp_valid_o     <= 1'b1;
                        resp_err_o       <= err_q;
                        resp_rdata_o     <= (we_q || err_q) ? '0 : ext_data;
                        state            <= RESP;
                    end else begin
                        cnt_q         <= nxt_cnt;
                        asm_q         <= asm_next;
                        mem_addr_o    <= addr_q + ADDR_W'(nxt_cnt);
                        mem_wr_data_o <= we_q ? XLEN'(wdata_q[8*nxt_cnt +: 8]) : '0;
                    end
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    resp_rdata_o <= '0;
                    resp_err_o   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of the data-memory port.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  pipeline presents a memory request.
REQ-006 req_ready_o  out  1  lsu_ctrl accepts the request this cycle.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_addr_i  in  ADDR_W  byte address.
REQ-009 req_wdata_i  in  XLEN  store data.
REQ-010 req_load_type_i  in  3  LB/LBU/LH/LHU/LW code.
REQ-011 req_store_type_i  in  2  SB/SH/SW code.
REQ-012 resp_valid_o  out  1  one-cycle completion pulse.
REQ-013 resp_rdata_o  out  XLEN  load result, extended; 0 for stores.
REQ-014 resp_err_o  out  1  access faulted; qualified by resp_valid_o.
REQ-015 mem_rd_en_o, mem_wr_en_o  out  1 each  data-memory enables.
REQ-016 mem_addr_o  out  ADDR_W; mem_wr_data_o  out  XLEN; mem_load_type_o  out  3; mem_store_type_o  out  2.
REQ-017 mem_rd_data_i  in  XLEN  data-memory read data (combinational from address).

Function
REQ-018 FSM states IDLE, ACCESS, SPLIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-019 Handshake: request accepted at the edge where req_valid_i & req_ready_o; all request fields registered at that edge.
REQ-020 Aligned access (LW/SW addr[1:0]=0, LH/LHU/SH addr[0]=0, byte always): IDLE->ACCESS; in ACCESS exactly one enable is high for one cycle with registered addr/type/data.
REQ-021 Loads: mem_rd_data_i captured at end of ACCESS; ACCESS->RESP; resp_valid_o=1 in RESP for exactly one cycle; RESP->IDLE.
REQ-022 Latency: accepted at edge N, memory cycle N..N+1, resp_valid_o high in cycle N+2 (aligned).
REQ-023 Stores: same timing; resp_rdata_o=0, resp_err_o=0.
REQ-024 Undefined load code SHALL be treated as LW; undefined store code (2'b11) SHALL issue no write and respond resp_err_o=1.
REQ-025 Enables and mem_* data SHALL be 0 in IDLE and RESP; no back-pressure on responses.
REQ-026 Address arithmetic wraps modulo 2^ADDR_W (e.g. 8'hFF+1=8'h00).

Reset
REQ-027 rst_n low: state=IDLE, all outputs 0 except req_ready_o=1 once reset is released; captured data cleared.
REQ-028 Reset mid-operation aborts the access immediately: enables drop asynchronously, no resp_valid_o is produced.

Configuration
REQ-029 Macro LSU_MISALIGN_SPLIT_EN defined: misaligned half/word access SHALL be split into k byte accesses (k=2 or 4), one per cycle in SPLIT, ascending addresses, using LBU/SB codes; bytes assembled little-endian, sign/zero extension applied after the last byte; resp_valid_o in cycle N+k+1; resp_err_o=0.
REQ-030 Macro undefined: misaligned access SHALL issue no memory enable; resp_valid_o in cycle N+2 with resp_err_o=1, resp_rdata_o=0; SPLIT is unreachable.

Structure
REQ-031 Load/store type codes, FSM state encoding and XLEN default SHALL live in the shared CPU package, shared with data memory and decoder.
REQ-032 One sub-module lsu_extend (combinational byte/half extension by load type) SHALL be used for both aligned and split results.

Verification
REQ-033 Reset with req_valid_i=1 -> no enable, req_ready_o=1 after release, resp_valid_o=0.
REQ-034 SW 32'hDEADBEEF @8'h10, then LW @8'h10 -> mem_wr_en_o pulse one cycle, load resp_rdata_o=32'hDEADBEEF at N+2.
REQ-035 Mem bytes @8'h20=8'h80 -> LB gives 32'hFFFFFF80, LBU gives 32'h00000080.
REQ-036 With LSU_MISALIGN_SPLIT_EN: LW @8'h21 over bytes 11,22,33,44 -> four read cycles at 21..24, resp 32'h44332211 at N+5; without: resp_err_o=1, no enable.
REQ-037 SH 16'hBEEF @8'hFF with split enabled -> SB 8'hEF @8'hFF then 8'hBE @8'h00 (wrap).
REQ-038 rst_n pulsed low during SPLIT cycle 2 -> enables drop same cycle, no resp_valid_o, next request served normally.
